aes_ciphertext_writer: RTL and testbench

Sink-side controller for the AES HWPE. It accepts one 128-bit ciphertext block from the AES engine and drains it as four 32-bit words to the ciphertext sink streamer, one single-word transaction per word. It issues the streamer's req_start, waits for ready_start and done, then reports completion. It is the write-direction counterpart of the plaintext fetch sequencing and sits between the engine output and the sink streamer.

---
 rtl/aes_ciphertext_writer_if.sv | 39 +++
 rtl/aes_ciphertext_writer.sv | 113 +++++++++++
 tb/tb_aes_ciphertext_writer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ciphertext_writer_if.sv
// Handshake bundle between the ciphertext writer, the AES engine output and the sink streamer.
// master: writer side; slave: engine/streamer/controller side.
interface aes_ciphertext_writer_if #(
  parameter int NB_WORDS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int IDX_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

  logic                           clear;
  logic [ADDR_WIDTH-1:0]          base_addr_i;
  logic                           ct_valid_i;
  logic                           ct_ready_o;
  logic [NB_WORDS*DATA_WIDTH-1:0] ct_data_i;
  logic                           sink_req_start_o;
  logic [ADDR_WIDTH-1:0]          sink_base_addr_o;
  logic                           sink_ready_start_i;
  logic                           sink_done_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [DATA_WIDTH-1:0]          out_data_o;
  logic                           busy_o;
  logic                           done_o;
  logic [IDX_W-1:0]               word_idx_o;

  modport master (
    input  clear, base_addr_i, ct_valid_i, ct_data_i,
           sink_ready_start_i, sink_done_i, out_ready_i,
    output ct_ready_o, sink_req_start_o, sink_base_addr_o,
           out_valid_o, out_data_o, busy_o, done_o, word_idx_o
  );

  modport slave (
    output clear, base_addr_i, ct_valid_i, ct_data_i,
           sink_ready_start_i, sink_done_i, out_ready_i,
    input  ct_ready_o, sink_req_start_o, sink_base_addr_o,
           out_valid_o, out_data_o, busy_o, done_o, word_idx_o
  );
endinterface

// File: rtl/aes_ciphertext_writer.sv
// Drains one ciphertext block as NB_WORDS single-word sink transactions.
// Optional AES_WRITER_BYTESWAP_EN: byte-reverse each emitted word.
module aes_ciphertext_writer #(
  parameter int NB_WORDS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  aes_ciphertext_writer_if.master bus
);
  localparam int IDX_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_STREAM, S_WAIT_DONE, S_FINISHED
  } state_t;

  state_t                         r_state, w_state_next;
  logic [IDX_W-1:0]               r_word_idx, w_word_idx_next;
  logic [NB_WORDS*DATA_WIDTH-1:0] r_buffer, w_buffer_next;
  logic [DATA_WIDTH-1:0]          w_words [NB_WORDS];
  logic [DATA_WIDTH-1:0]          w_word;
  logic [DATA_WIDTH-1:0]          w_word_out;

  for (genvar gi = 0; gi < NB_WORDS; gi++) begin : g_words
    assign w_words[gi] = r_buffer[gi*DATA_WIDTH +: DATA_WIDTH];
  end
  assign w_word = w_words[r_word_idx];

`ifdef AES_WRITER_BYTESWAP_EN
  for (genvar gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_swap
    assign w_word_out[gi*8 +: 8] = w_word[DATA_WIDTH-8-gi*8 +: 8];
  end
`else
  assign w_word_out = w_word;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_word_idx <= '0;
      r_buffer   <= '0;
    end else if (bus.clear) begin
      r_state    <= S_IDLE;
      r_word_idx <= '0;
      r_buffer   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_word_idx <= w_word_idx_next;
      r_buffer   <= w_buffer_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_word_idx_next = r_word_idx;
    w_buffer_next   = r_buffer;
    case (r_state)
      S_IDLE: begin
        if (bus.ct_valid_i) begin
          w_buffer_next   = bus.ct_data_i;
          w_word_idx_next = '0;
          w_state_next    = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (bus.sink_ready_start_i) w_state_next = S_STREAM;
      end
      S_STREAM, S_WAIT_DONE: begin
        // A done arriving together with the word handshake takes the WAIT_DONE exit directly.
        if (r_state == S_STREAM && !bus.out_ready_i) begin
          w_state_next = S_STREAM;
        end else if (bus.sink_done_i) begin
          if (r_word_idx == LAST_IDX) begin
            w_state_next = S_FINISHED;
          end else begin
            w_word_idx_next = r_word_idx + IDX_W'(1);
            w_state_next    = S_REQUEST;
          end
        end else begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_FINISHED: w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ct_ready_o       = 1'b0;
    bus.sink_req_start_o = 1'b0;
    bus.sink_base_addr_o = '0;
    bus.out_valid_o      = 1'b0;
    bus.out_data_o       = '0;
    bus.done_o           = 1'b0;
    bus.busy_o           = (r_state != S_IDLE);
    bus.word_idx_o       = r_word_idx;
    case (r_state)
      S_IDLE:     bus.ct_ready_o = 1'b1;
      S_REQUEST: begin
        bus.sink_req_start_o = 1'b1;
        bus.sink_base_addr_o = bus.base_addr_i + (ADDR_WIDTH'(r_word_idx) << 2);
      end
      S_STREAM: begin
        bus.out_valid_o = 1'b1;
        bus.out_data_o  = w_word_out;
      end
      S_FINISHED: bus.done_o = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aes_ciphertext_writer.sv
// Directed self-checking bench for aes_ciphertext_writer; inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_aes_ciphertext_writer;
  localparam int NB_WORDS   = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
`ifdef AES_WRITER_BYTESWAP_EN
  localparam logic [31:0] BS_W0 = 32'h44332211;
`else
  localparam logic [31:0] BS_W0 = 32'h11223344;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  aes_ciphertext_writer_if #(.NB_WORDS(NB_WORDS), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  aes_ciphertext_writer #(.NB_WORDS(NB_WORDS), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef AES_WRITER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic start_block(input logic [31:0] base, input logic [127:0] data);
    check("ct_ready_idle", bus.ct_ready_o, 1'b1);
    bus.base_addr_i = base;
    bus.ct_data_i   = data;
    bus.ct_valid_i  = 1'b1;
    tick();
    bus.ct_valid_i  = 1'b0;
    check("busy_after_accept", bus.busy_o, 1'b1);
    check("req_after_accept", bus.sink_req_start_o, 1'b1);
  endtask

  task automatic do_word(input int idx, input logic [31:0] addr, input logic [31:0] data,
                         input int rs, input int dd, input int bp, input bit coinc, input bit spur);
    int k = 0;
    while (!bus.sink_req_start_o && k < 20) begin
      tick();
      k++;
    end
    check("req_start", bus.sink_req_start_o, 1'b1);
    check("addr", bus.sink_base_addr_o, addr);
    check("word_idx", bus.word_idx_o, idx);
    for (int i = 0; i < rs; i++) begin
      if (spur && i == 0) bus.sink_done_i = 1'b1;
      tick();
      bus.sink_done_i = 1'b0;
      check("req_hold", bus.sink_req_start_o, 1'b1);
      check("req_hold_idx", bus.word_idx_o, idx);
    end
    bus.sink_ready_start_i = 1'b1;
    tick();
    bus.sink_ready_start_i = 1'b0;
    check("out_valid", bus.out_valid_o, 1'b1);
    check("out_data", bus.out_data_o, data);
    check("addr_zero_stream", bus.sink_base_addr_o, 32'h0);
    for (int i = 0; i < bp; i++) begin
      if (i == 0) begin
        bus.ct_valid_i = 1'b1;
        bus.ct_data_i  = '1;
      end
      tick();
      check("bp_ct_ready", bus.ct_ready_o, 1'b0);
      check("bp_valid", bus.out_valid_o, 1'b1);
      check("bp_data", bus.out_data_o, data);
      check("bp_idx", bus.word_idx_o, idx);
    end
    bus.ct_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    if (coinc) bus.sink_done_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    bus.sink_done_i = 1'b0;
    $display("word %0d addr %08h data %08h", idx, addr, data);
    if (coinc) begin
      if (idx != NB_WORDS - 1) begin
        check("coinc_req", bus.sink_req_start_o, 1'b1);
        check("coinc_idx", bus.word_idx_o, idx + 1);
      end
    end else begin
      check("wait_valid_low", bus.out_valid_o, 1'b0);
      check("wait_req_low", bus.sink_req_start_o, 1'b0);
      for (int i = 0; i < dd; i++) begin
        tick();
        check("wait_hold", bus.sink_req_start_o | bus.out_valid_o | bus.done_o, 1'b0);
      end
      bus.sink_done_i = 1'b1;
      tick();
      bus.sink_done_i = 1'b0;
    end
  endtask

  task automatic check_done();
    check("done_pulse", bus.done_o, 1'b1);
    tick();
    check("done_one_cycle", bus.done_o, 1'b0);
    check("idle_ct_ready", bus.ct_ready_o, 1'b1);
    check("idle_busy", bus.busy_o, 1'b0);
  endtask

  task automatic run_block(input logic [31:0] base, input logic [31:0] w[4], input logic [31:0] e[4],
                           input logic [31:0] a[4], input int rs, input int dd, input int bp_word,
                           input int coinc_mask, input bit spur);
    start_block(base, {w[3], w[2], w[1], w[0]});
    for (int i = 0; i < NB_WORDS; i++)
      do_word(i, a[i], e[i], rs, dd, (i == bp_word) ? 5 : 0, coinc_mask[i], spur && (i == 0));
    check_done();
  endtask

  initial begin
    logic [31:0] w[4], e[4], a[4];
    bit seen;
    bus.clear = 1'b0; bus.base_addr_i = '0; bus.ct_valid_i = 1'b0; bus.ct_data_i = '0;
    bus.sink_ready_start_i = 1'b0; bus.sink_done_i = 1'b0; bus.out_ready_i = 1'b0;
    #12;
    check("rst_ct_ready", bus.ct_ready_o, 1'b1);
    check("rst_outputs", {bus.sink_req_start_o, bus.out_valid_o, bus.busy_o, bus.done_o}, 4'b0);
    check("rst_addr", bus.sink_base_addr_o, 32'h0);
    check("rst_data", bus.out_data_o, 32'h0);
    check("rst_idx", bus.word_idx_o, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Nominal block
    w = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
    e = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
    a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    run_block(32'h1000, w, e, a, 1, 1, -1, 0, 1'b0);

    // Backpressure on word 2 with an intruding ct_valid
    w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    for (int i = 0; i < 4; i++) e[i] = exp_word(w[i]);
    a = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
    run_block(32'h2000, w, e, a, 0, 0, 2, 0, 1'b0);

    // Address wrap, coincident done on words 1 and 3
    w = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    for (int i = 0; i < 4; i++) e[i] = exp_word(w[i]);
    a = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    run_block(32'hFFFFFFF8, w, e, a, 0, 0, -1, 4'b1010, 1'b0);

    // Clear during STREAM of word 2, then a fresh block
    w = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD};
    start_block(32'h3000, {w[3], w[2], w[1], w[0]});
    do_word(0, 32'h3000, exp_word(w[0]), 0, 0, 0, 1'b0, 1'b0);
    do_word(1, 32'h3004, exp_word(w[1]), 0, 0, 0, 1'b0, 1'b0);
    check("abort_req", bus.sink_req_start_o, 1'b1);
    bus.sink_ready_start_i = 1'b1;
    tick();
    bus.sink_ready_start_i = 1'b0;
    check("abort_stream", bus.out_valid_o, 1'b1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("abort_ct_ready", bus.ct_ready_o, 1'b1);
    check("abort_busy", bus.busy_o, 1'b0);
    check("abort_idx", bus.word_idx_o, 2'd0);
    check("abort_valid", bus.out_valid_o, 1'b0);
    seen = bus.done_o;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen |= bus.done_o;
    end
    check("abort_no_done", seen, 1'b0);
    w = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978};
    for (int i = 0; i < 4; i++) e[i] = exp_word(w[i]);
    a = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
    run_block(32'h3000, w, e, a, 0, 0, -1, 0, 1'b0);

    // Byte order and spurious done in REQUEST
    w = '{32'h11223344, 32'h55667788, 32'hDEADBEEF, 32'hCAFEBABE};
    for (int i = 0; i < 4; i++) e[i] = exp_word(w[i]);
    e[0] = BS_W0;
    a = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
    run_block(32'h4000, w, e, a, 2, 0, -1, 0, 1'b1);

    // Asynchronous reset mid-block, away from any clock edge
    start_block(32'h5000, 128'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_ct_ready", bus.ct_ready_o, 1'b1);
    check("async_busy", bus.busy_o, 1'b0);
    check("async_req", bus.sink_req_start_o, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", bus.ct_ready_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
